// File: rtl/prod_accumulator.sv
// Saturating accumulator that sums COUNT unsigned multiplier products per result
// and hands the sum plus a sticky overflow flag downstream over valid/ready.
module prod_accumulator #(
   parameter int P_W   = 8,
   parameter int ACC_W = 12,
   parameter int COUNT = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [P_W-1:0]               in_p,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ACC_W-1:0]             out_sum,
   output logic                         out_ovf,
   output logic [$clog2(COUNT+1)-1:0]   beat_cnt
);

   localparam int CW = $clog2(COUNT+1);

   typedef enum logic {ACCUM, DONE} state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] out_sum_q, out_sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;
   logic             out_ovf_q, out_ovf_d;

   logic [ACC_W:0]   sum_ext;
   logic [ACC_W-1:0] sum_sat;
   logic             accept;
   logic             last;

   function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] s);
      if (s[ACC_W]) return {ACC_W{1'b1}};
      else          return s[ACC_W-1:0];
   endfunction

   assign in_ready = (state_q == ACCUM);
   assign accept   = in_valid && in_ready;
   assign sum_ext  = {1'b0, acc_q} + {{(ACC_W+1-P_W){1'b0}}, in_p};
   assign sum_sat  = sat_acc(sum_ext);
   assign last     = (cnt_q == CW'(COUNT-1));

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_ovf_d   = out_ovf_q;
      // clear wins over any beat or handshake in the same cycle
      if (clear) begin
         state_d     = ACCUM;
         acc_d       = '0;
         cnt_d       = '0;
         ovf_d       = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (accept) begin
                  acc_d = sum_sat;
                  ovf_d = ovf_q | sum_ext[ACC_W];
                  cnt_d = cnt_q + CW'(1);
                  if (last) begin
                     state_d     = DONE;
                     out_sum_d   = sum_sat;
                     out_ovf_d   = ovf_q | sum_ext[ACC_W];
                     out_valid_d = 1'b1;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d     = ACCUM;
                  acc_d       = '0;
                  cnt_d       = '0;
                  ovf_d       = 1'b0;
                  out_valid_d = 1'b0;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_ovf   = out_ovf_q;
   assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// Bench for prod_accumulator: a default instance and a 9-bit accumulator instance
// share stimulus and are compared each cycle against a batch-sum reference model.
module tb_prod_accumulator;

   localparam int CNT = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear;
   logic       in_valid;
   logic       out_ready;
   logic [7:0] in_p;

   logic        in_ready0, out_valid0, out_ovf0;
   logic [11:0] out_sum0;
   logic [2:0]  beat_cnt0;
   logic        in_ready1, out_valid1, out_ovf1;
   logic [8:0]  out_sum1;
   logic [2:0]  beat_cnt1;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state, index 0 = ACC_W 12, index 1 = ACC_W 9
   int maxv[2] = '{4095, 511};
   int m_total[2];
   int m_cnt[2];
   int m_done[2];
   int m_ov[2];
   int m_os[2];
   int m_oo[2];

   prod_accumulator #(.P_W(8), .ACC_W(12), .COUNT(CNT)) dut0 (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready0), .in_p(in_p),
      .out_valid(out_valid0), .out_ready(out_ready),
      .out_sum(out_sum0), .out_ovf(out_ovf0), .beat_cnt(beat_cnt0)
   );

   prod_accumulator #(.P_W(8), .ACC_W(9), .COUNT(CNT)) dut1 (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready1), .in_p(in_p),
      .out_valid(out_valid1), .out_ready(out_ready),
      .out_sum(out_sum1), .out_ovf(out_ovf1), .beat_cnt(beat_cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_total[i] = 0; m_cnt[i] = 0; m_done[i] = 0;
         m_ov[i] = 0; m_os[i] = 0; m_oo[i] = 0;
      end
   endtask

   task automatic model_edge(input int v, input int p, input int ordy, input int clr);
      for (int i = 0; i < 2; i++) begin
         if (clr != 0) begin
            m_done[i] = 0; m_cnt[i] = 0; m_total[i] = 0; m_ov[i] = 0;
         end else if (m_done[i] == 0) begin
            if (v != 0) begin
               m_total[i] += p;
               m_cnt[i]++;
               if (m_cnt[i] == CNT) begin
                  m_done[i] = 1;
                  m_ov[i]   = 1;
                  m_os[i]   = (m_total[i] > maxv[i]) ? maxv[i] : m_total[i];
                  m_oo[i]   = (m_total[i] > maxv[i]) ? 1 : 0;
               end
            end
         end else if (ordy != 0) begin
            m_done[i] = 0; m_cnt[i] = 0; m_total[i] = 0; m_ov[i] = 0;
         end
      end
   endtask

   task automatic check_outs(input string tag);
      chk({tag, "_ovalid0"}, int'(out_valid0), m_ov[0]);
      chk({tag, "_osum0"},   int'(out_sum0),   m_os[0]);
      chk({tag, "_oovf0"},   int'(out_ovf0),   m_oo[0]);
      chk({tag, "_bcnt0"},   int'(beat_cnt0),  m_cnt[0]);
      chk({tag, "_ovalid1"}, int'(out_valid1), m_ov[1]);
      chk({tag, "_osum1"},   int'(out_sum1),   m_os[1]);
      chk({tag, "_oovf1"},   int'(out_ovf1),   m_oo[1]);
      chk({tag, "_bcnt1"},   int'(beat_cnt1),  m_cnt[1]);
   endtask

   // called 1 time unit after a rising edge; returns 1 time unit after the next one
   task automatic cycle(input string tag, input int v, input int p, input int ordy, input int clr);
      in_valid  = (v != 0);
      in_p      = 8'(p);
      out_ready = (ordy != 0);
      clear     = (clr != 0);
      #1;
      chk({tag, "_irdy0"}, int'(in_ready0), (m_done[0] == 0) ? 1 : 0);
      chk({tag, "_irdy1"}, int'(in_ready1), (m_done[1] == 0) ? 1 : 0);
      @(posedge clk);
      model_edge(v, p, ordy, clr);
      #1;
      check_outs(tag);
   endtask

   task automatic batch(input string tag, input int a, input int b, input int c, input int d);
      cycle(tag, 1, a, 0, 0);
      cycle(tag, 1, b, 0, 0);
      cycle(tag, 1, c, 0, 0);
      cycle(tag, 1, d, 0, 0);
   endtask

   initial begin
      model_reset();
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_p = '0;
      #2;
      chk("rst_irdy", int'(in_ready0), 1);
      chk("rst_ovalid", int'(out_valid0), 0);
      chk("rst_osum", int'(out_sum0), 0);
      chk("rst_bcnt", int'(beat_cnt0), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: plain result
      batch("t1", 10, 20, 30, 48);
      chk("t1_sum", int'(out_sum0), 108);
      chk("t1_ovf", int'(out_ovf0), 0);
      chk("t1_valid", int'(out_valid0), 1);
      cycle("t1c", 0, 0, 1, 0);

      // 2: saturation on the 9-bit instance, then ovf cleared on the next result
      batch("t2a", 225, 225, 225, 225);
      chk("t2_sum9", int'(out_sum1), 511);
      chk("t2_ovf9", int'(out_ovf1), 1);
      chk("t2_sum12", int'(out_sum0), 900);
      cycle("t2c", 0, 0, 1, 0);
      batch("t2b", 1, 1, 1, 1);
      chk("t2_sum9b", int'(out_sum1), 4);
      chk("t2_ovf9b", int'(out_ovf1), 0);
      cycle("t2d", 0, 0, 1, 0);

      // 3: backpressure with an offered beat that must not be taken
      batch("t3", 10, 20, 30, 48);
      for (int k = 0; k < 5; k++) cycle("t3bp", 1, 99, 0, 0);
      chk("t3_sum", int'(out_sum0), 108);
      chk("t3_irdy", int'(in_ready0), 0);
      cycle("t3hs", 1, 99, 1, 0);
      chk("t3_irdy_after", int'(in_ready0), 1);
      chk("t3_bcnt_after", int'(beat_cnt0), 0);

      // 4: sparse input
      for (int k = 1; k <= 4; k++) begin
         int gap;
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) cycle("t4gap", 0, int'($urandom_range(0, 255)), 0, 0);
         cycle("t4", 1, k, 0, 0);
      end
      chk("t4_sum", int'(out_sum0), 10);
      cycle("t4c", 0, 0, 1, 0);

      // 5: clear mid-batch, then clear while a result is pending
      cycle("t5", 1, 50, 0, 0);
      cycle("t5", 1, 60, 0, 0);
      cycle("t5clr", 1, 70, 0, 1);
      chk("t5_bcnt", int'(beat_cnt0), 0);
      batch("t5b", 1, 1, 1, 1);
      chk("t5_sum", int'(out_sum0), 4);
      cycle("t5clr2", 0, 0, 1, 1);
      chk("t5_valid", int'(out_valid0), 0);
      cycle("t5idle", 0, 0, 0, 0);

      // 6: asynchronous reset between edges
      cycle("t6", 1, 5, 0, 0);
      cycle("t6", 1, 5, 0, 0);
      in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("t6_irdy", int'(in_ready0), 1);
      chk("t6_valid", int'(out_valid0), 0);
      chk("t6_sum", int'(out_sum0), 0);
      chk("t6_bcnt", int'(beat_cnt0), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      batch("t6b", 5, 5, 5, 5);
      chk("t6_sum20", int'(out_sum0), 20);
      cycle("t6c", 0, 0, 1, 0);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         int v, p, r, c;
         v = ($urandom_range(0, 3) != 0) ? 1 : 0;
         p = int'($urandom_range(0, 15) * $urandom_range(0, 15));
         r = ($urandom_range(0, 2) != 0) ? 1 : 0;
         c = ($urandom_range(0, 24) == 0) ? 1 : 0;
         cycle("rnd", v, p, r, c);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
